regfile_readback_checker: RTL and testbench
===========================================

# regfile_readback_checker

Hardware read-back checker for the CPU register file. It keeps a shadow copy of the expected value of each architectural register, loaded through the same write-side information the stimulus uses. On `start` it scans every register through one read port of `gen_regs_new` and compares it against the shadow. It reports pass/fail, the number of mismatches, and the first failing register, so CPU benches and self-test firmware get an automatic verdict instead of reading printed values.

## Interface
Parameters:
- `NREGS`, 32: number of registers scanned; addresses 0..NREGS-1.
- `XLEN`, 32: register data width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `exp_wen`  in  1  load an expected value into the shadow.
- `exp_addr`  in  5  shadow address for `exp_wen`.
- `exp_data`  in  XLEN  expected value for `exp_wen`.
- `exp_clr`  in  1  clears all shadow valid bits.
- `start`  in  1  single-cycle request to begin a scan.
- `regRAddr`  out  5  register-file read address; drive to `regRAddr1` or `regRAddr2`.
- `regRData`  in  XLEN  register-file read data; combinational read of `regRAddr`.
- `busy`  out  1  scan in progress.
- `done`  out  1  one-cycle pulse when results are final.
- `pass`  out  1  1 when the last scan had zero mismatches.
- `err_count`  out  6  number of mismatching registers in the last scan.
- `first_err_addr`  out  5  lowest mismatching address.
- `first_err_data`  out  XLEN  value actually read at `first_err_addr`.

## Operation
- **Shadow.** The shadow is an array of NREGS x XLEN values plus NREGS valid bits. `exp_wen` in IDLE writes the value and sets its valid bit; the last write wins. Registers with a clear valid bit are not compared.
- **Clearing the shadow.** `exp_clr` in IDLE clears all valid bits. If `exp_clr` and `exp_wen` occur in the same cycle, the clear applies first and then the write, so the written entry ends up valid.
- **Writes during a scan.** `exp_wen`, `exp_clr` and `start` are ignored while `busy` is high.
- **FSM states:** IDLE, SCAN, DRAIN, DONE.
  - IDLE -> SCAN on `start`. Entering SCAN clears `err_count`, `first_err_*` and `pass`.
  - SCAN: an address counter drives `regRAddr` from 0 to NREGS-1, one address per cycle. Each cycle, stage 1 registers `{addr, regRData, shadow[addr], valid[addr]}`.
  - SCAN -> DRAIN after address NREGS-1 is captured.
  - DRAIN: stage 2 compares the last captured entry.
  - DRAIN -> DONE.
  - DONE -> IDLE unconditionally.
- **Stage 2 comparison** (runs every cycle in SCAN and DRAIN): if the entry is valid and the read data differs from the expected value, `err_count` increments, saturating at 63. On the first mismatch only, `first_err_addr` and `first_err_data` are latched.
- **Results.** `pass` = (`err_count` == 0), written on entry to DONE. Results hold until the next `start`.
- **Address 0.** x0 handling is set by `REGCHK_X0_EN`; see Configuration.

## Timing
- **Reset values:** `regRAddr`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_addr`=0, `first_err_data`=0. All shadow valid bits=0, and the FSM is in IDLE.
- **Scan sequence.** `start` is sampled high at edge E0.
  - Cycles 1..NREGS after E0: SCAN, with `regRAddr` = 0..NREGS-1.
  - Cycle NREGS+1: DRAIN.
  - Cycle NREGS+2: DONE, with `done`=1 and final `pass`.
- **Latency:** `busy` is high for exactly NREGS+1 cycles, which is 33 for the defaults. Start to `done` is 34 cycles.
- **Read settling:** `regRData` is sampled in the same cycle its address is driven, so the register-file read must settle within one cycle.
- **Back-to-back scans:** `start` in the DONE cycle is ignored. `start` in the following IDLE cycle is accepted.
- **Reset mid-scan:** outputs, shadow valid bits and FSM return to their reset values immediately. No `done` pulse is produced.

## Configuration
- **`REGCHK_X0_EN` defined:** address 0 is always compared against 0, regardless of its valid bit. `exp_wen` to address 0 is ignored.
- **`REGCHK_X0_EN` undefined:** address 0 is never compared. `exp_wen` to address 0 is stored but has no effect on the result.

## Test plan
- **Matching values.** Load x1=12345678 and x2=DEADBEEF; the register file holds the same values. Pulse `start` -> `done` 34 cycles later, `pass`=1, `err_count`=0.
- **Single mismatch.** Expected x2=DEADBEEF, register file returns DEADBEEE -> `pass`=0, `err_count`=1, `first_err_addr`=2, `first_err_data`=DEADBEEE.
- **Multiple mismatches.** x3 and x7 are wrong -> `err_count`=2, `first_err_addr`=3. Rerun with both fixed -> `pass`=1 and all error fields cleared.
- **x0 handling.** Write `exp_wen` x0=FFFFFFFF; register file x0=0 -> `pass`=1 in both builds. Force the model's x0 to 1 -> `err_count`=1 with `REGCHK_X0_EN`, 0 without.
- **Ignored inputs and reset.** `start`, `exp_wen` and `exp_clr` during `busy` -> no effect on shadow or timing. Assert `reset` at scan cycle 10 -> all outputs 0, no `done`. A following scan with an empty shadow gives `pass`=1.
- **Shadow clear.** `exp_clr` after loading 5 mismatching entries, then `start` -> `pass`=1, `err_count`=0.

Source files
------------

// File: rtl/regfile_readback_checker.sv
// ----------------------------------------------------------------------------
// regfile_readback_checker
//
// Purpose: hardware read-back checker for the CPU register file. A shadow
// copy of the expected register values is loaded through exp_wen/exp_addr/
// exp_data. On start, every register 0..NREGS-1 is read through one read
// port (regRAddr/regRData) and compared against the shadow. The scan reports
// pass/fail, the number of mismatching registers and the first failure.
//
// Configuration macro: REGCHK_X0_EN
//   defined   : address 0 is always compared against zero; exp_wen to 0 ignored
//   undefined : address 0 is never compared; exp_wen to 0 stored but unused
//
// Ports:
//   clk             in   clock, rising edge
//   reset           in   asynchronous active-high reset
//   exp_wen         in   write an expected value into the shadow (IDLE only)
//   exp_addr  [4:0] in   shadow address for exp_wen
//   exp_data  [X]   in   expected value for exp_wen
//   exp_clr         in   clear all shadow valid bits (IDLE only)
//   start           in   single-cycle scan request (IDLE only)
//   regRAddr  [4:0] out  register-file read address
//   regRData  [X]   in   register-file read data (combinational read)
//   busy            out  scan in progress (SCAN and DRAIN)
//   done            out  one-cycle pulse when results are final
//   pass            out  last scan had no mismatches
//   err_count [5:0] out  number of mismatching registers, saturating
//   first_err_addr  out  lowest mismatching address
//   first_err_data  out  value read at first_err_addr
// ----------------------------------------------------------------------------
module regfile_readback_checker #(
   parameter int unsigned NREGS = 32,
   parameter int unsigned XLEN  = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            exp_wen,
   input  logic [4:0]      exp_addr,
   input  logic [XLEN-1:0] exp_data,
   input  logic            exp_clr,
   input  logic            start,
   output logic [4:0]      regRAddr,
   input  logic [XLEN-1:0] regRData,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [5:0]      err_count,
   output logic [4:0]      first_err_addr,
   output logic [XLEN-1:0] first_err_data
);

   localparam int unsigned AW    = 5;
   localparam int unsigned CW    = 6;
   localparam int unsigned DEPTH = 32;

   localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 1);
   localparam logic [CW-1:0] CNT_MAX   = '1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SCAN  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   // Shadow storage covers the full address space so any exp_addr is a legal
   // write target; only entries 0..NREGS-1 are ever scanned.
   logic [XLEN-1:0]  r_shadow [DEPTH];
   logic [DEPTH-1:0] r_valid;
   logic [DEPTH-1:0] w_valid_nxt;

   logic [AW-1:0]    r_addr;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic [CW-1:0]    r_err_count;
   logic [AW-1:0]    r_first_addr;
   logic [XLEN-1:0]  r_first_data;

   // Stage-1 capture of one scanned register
   logic             r_s1_vld;
   logic             r_s1_cmp;
   logic [AW-1:0]    r_s1_addr;
   logic [XLEN-1:0]  r_s1_rdata;
   logic [XLEN-1:0]  r_s1_exp;

   logic             w_idle;
   logic             w_start_acc;
   logic             w_wr;
   logic             w_cmp_en;
   logic [XLEN-1:0]  w_exp_val;
   logic             w_mismatch;
   logic [CW-1:0]    w_err_nxt;

   assign w_idle      = (r_state == S_IDLE);
   assign w_start_acc = w_idle && start;

`ifdef REGCHK_X0_EN
   // x0 is hardwired: never stored, always checked against zero
   assign w_wr      = w_idle && exp_wen && (exp_addr != '0);
   assign w_cmp_en  = (r_addr == '0) ? 1'b1 : r_valid[r_addr];
   assign w_exp_val = (r_addr == '0) ? '0 : r_shadow[r_addr];
`else
   // x0 may be stored but is excluded from the comparison
   assign w_wr      = w_idle && exp_wen;
   assign w_cmp_en  = (r_addr != '0) && r_valid[r_addr];
   assign w_exp_val = r_shadow[r_addr];
`endif

   // Valid-bit update: clear applies before a same-cycle write
   always_comb begin
      w_valid_nxt = r_valid;
      if (w_idle && exp_clr) begin
         w_valid_nxt = '0;
      end
      if (w_wr) begin
         w_valid_nxt[exp_addr] = 1'b1;
      end
   end

   // Shadow data (no reset needed; qualified by valid bits)
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_shadow[exp_addr] <= exp_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= '0;
      end else begin
         r_valid <= w_valid_nxt;
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_SCAN;
         S_SCAN:  if (r_addr == LAST_ADDR) w_state_nxt = S_DRAIN;
         S_DRAIN: w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Stage-2 compare and saturating error count
   assign w_mismatch = r_s1_vld && r_s1_cmp && (r_s1_rdata != r_s1_exp);

   always_comb begin
      w_err_nxt = r_err_count;
      if (w_mismatch && (r_err_count != CNT_MAX)) begin
         w_err_nxt = r_err_count + CW'(1);
      end
   end

   // Scan datapath and result registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr       <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_err_count  <= '0;
         r_first_addr <= '0;
         r_first_data <= '0;
         r_s1_vld     <= 1'b0;
         r_s1_cmp     <= 1'b0;
         r_s1_addr    <= '0;
         r_s1_rdata   <= '0;
         r_s1_exp     <= '0;
      end else begin
         r_busy   <= (w_state_nxt == S_SCAN) || (w_state_nxt == S_DRAIN);
         r_done   <= (w_state_nxt == S_DONE);
         r_s1_vld <= (r_state == S_SCAN);

         if (r_state == S_SCAN) begin
            r_s1_cmp   <= w_cmp_en;
            r_s1_addr  <= r_addr;
            r_s1_rdata <= regRData;
            r_s1_exp   <= w_exp_val;
            r_addr     <= (r_addr == LAST_ADDR) ? '0 : r_addr + AW'(1);
         end

         if (w_start_acc) begin
            r_addr       <= '0;
            r_pass       <= 1'b0;
            r_err_count  <= '0;
            r_first_addr <= '0;
            r_first_data <= '0;
         end else begin
            r_err_count <= w_err_nxt;
            // Addresses scan upward, so the first mismatch is the lowest
            if (w_mismatch && (r_err_count == '0)) begin
               r_first_addr <= r_s1_addr;
               r_first_data <= r_s1_rdata;
            end
            // Verdict includes the compare of the final entry in DRAIN
            if (r_state == S_DRAIN) begin
               r_pass <= (w_err_nxt == '0);
            end
         end
      end
   end

   assign regRAddr       = r_addr;
   assign busy           = r_busy;
   assign done           = r_done;
   assign pass           = r_pass;
   assign err_count      = r_err_count;
   assign first_err_addr = r_first_addr;
   assign first_err_data = r_first_data;

endmodule

// File: tb/tb_regfile_readback_checker.sv
// ----------------------------------------------------------------------------
// tb_regfile_readback_checker
//
// Purpose: directed self-checking bench for regfile_readback_checker. A
// behavioural register file (rf) answers the combinational read port; each
// scenario sets rf and the shadow, runs a scan and compares the results with
// hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_regfile_readback_checker;

   localparam int unsigned NREGS = 32;
   localparam int unsigned XLEN  = 32;

   logic            clk;
   logic            reset;
   logic            exp_wen;
   logic [4:0]      exp_addr;
   logic [XLEN-1:0] exp_data;
   logic            exp_clr;
   logic            start;
   logic [4:0]      regRAddr;
   logic [XLEN-1:0] regRData;
   logic            busy;
   logic            done;
   logic            pass;
   logic [5:0]      err_count;
   logic [4:0]      first_err_addr;
   logic [XLEN-1:0] first_err_data;

   logic [XLEN-1:0] rf [NREGS];

   int n_tests;
   int n_fail;

   regfile_readback_checker #(
      .NREGS (NREGS),
      .XLEN  (XLEN)
   ) u_dut (
      .clk            (clk),
      .reset          (reset),
      .exp_wen        (exp_wen),
      .exp_addr       (exp_addr),
      .exp_data       (exp_data),
      .exp_clr        (exp_clr),
      .start          (start),
      .regRAddr       (regRAddr),
      .regRData       (regRData),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .err_count      (err_count),
      .first_err_addr (first_err_addr),
      .first_err_data (first_err_data)
   );

   assign regRData = rf[regRAddr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
      n_tests++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [4:0] a, input logic [XLEN-1:0] d);
      exp_wen  = 1'b1;
      exp_addr = a;
      exp_data = d;
      tick();
      exp_wen  = 1'b0;
   endtask

   task automatic clear_shadow();
      exp_clr = 1'b1;
      tick();
      exp_clr = 1'b0;
   endtask

   // Runs one scan and checks timing plus results. poke drives start/exp_wen/
   // exp_clr during busy; b2b drives start in the DONE cycle.
   task automatic scan_and_check(input string tag, input bit poke, input bit b2b,
                                 input bit e_pass, input int e_err,
                                 input int e_faddr, input logic [XLEN-1:0] e_fdata);
      int lat;
      int busy_cyc;
      bit addr_ok;
      start = 1'b1;
      tick();
      start    = 1'b0;
      lat      = 1;
      busy_cyc = 0;
      addr_ok  = 1'b1;
      while (!done && lat < 200) begin
         if (busy) busy_cyc++;
         if (lat <= NREGS && 32'(regRAddr) != 32'(lat - 1)) addr_ok = 1'b0;
         exp_wen  = poke && (lat == 5);
         exp_clr  = poke && (lat == 5);
         start    = poke && (lat == 5);
         exp_addr = 5'd9;
         exp_data = 32'h0000_0BAD;
         tick();
         lat++;
         exp_wen = 1'b0;
         exp_clr = 1'b0;
         start   = 1'b0;
      end
      check({tag, "_done"},  64'(done), 64'(1));
      check({tag, "_lat"},   64'(lat), 64'(34));
      check({tag, "_busy"},  64'(busy_cyc), 64'(33));
      check({tag, "_raddr"}, 64'(addr_ok), 64'(1));
      check({tag, "_pass"},  64'(pass), 64'(e_pass));
      check({tag, "_err"},   64'(err_count), 64'(e_err));
      check({tag, "_faddr"}, 64'(first_err_addr), 64'(e_faddr));
      check({tag, "_fdata"}, 64'(first_err_data), 64'(e_fdata));
      start = b2b;
      tick();
      start = 1'b0;
      check({tag, "_pulse"}, 64'(done), 64'(0));
      if (b2b) check({tag, "_b2b_ign"}, 64'(busy), 64'(0));
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_raddr"}, 64'(regRAddr), 64'(0));
      check({tag, "_busy"},  64'(busy), 64'(0));
      check({tag, "_done"},  64'(done), 64'(0));
      check({tag, "_pass"},  64'(pass), 64'(0));
      check({tag, "_err"},   64'(err_count), 64'(0));
      check({tag, "_faddr"}, 64'(first_err_addr), 64'(0));
      check({tag, "_fdata"}, 64'(first_err_data), 64'(0));
   endtask

   initial begin
      bit saw_done;
      n_tests  = 0;
      n_fail   = 0;
      reset    = 1'b1;
      exp_wen  = 1'b0;
      exp_addr = '0;
      exp_data = '0;
      exp_clr  = 1'b0;
      start    = 1'b0;
      for (int i = 0; i < NREGS; i++) rf[i] = 32'h1000_0000 + 32'(i);
      rf[0] = '0;
      rf[1] = 32'h1234_5678;
      rf[2] = 32'hDEAD_BEEF;

      repeat (3) tick();
      check_outputs_zero("rst");
      reset = 1'b0;
      tick();
      check_outputs_zero("rst_rel");

      // Matching values
      load(5'd1, 32'h1234_5678);
      load(5'd2, 32'hDEAD_BEEF);
      scan_and_check("match", 1'b0, 1'b0, 1'b1, 0, 0, 32'h0);

      // Single mismatch
      rf[2] = 32'hDEAD_BEEE;
      scan_and_check("single", 1'b0, 1'b0, 1'b0, 1, 2, 32'hDEAD_BEEE);
      rf[2] = 32'hDEAD_BEEF;

      // Two mismatches, then fixed
      load(5'd3, 32'h0000_0033);
      load(5'd7, 32'h0000_0077);
      rf[3] = 32'h0000_0034;
      rf[7] = 32'h0000_0070;
      scan_and_check("multi", 1'b0, 1'b0, 1'b0, 2, 3, 32'h0000_0034);
      rf[3] = 32'h0000_0033;
      rf[7] = 32'h0000_0077;
      scan_and_check("fixed", 1'b0, 1'b0, 1'b1, 0, 0, 32'h0);

      // Reset in scan cycle 10 after a failing scan
      rf[7] = 32'h0000_0071;
      scan_and_check("pre_rst", 1'b0, 1'b0, 1'b0, 1, 7, 32'h0000_0071);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      check("midrst_busy_pre", 64'(busy), 64'(1));
      reset = 1'b1;
      #1;
      check_outputs_zero("midrst");
      tick();
      reset    = 1'b0;
      saw_done = 1'b0;
      repeat (40) begin
         tick();
         if (done || busy) saw_done = 1'b1;
      end
      check("midrst_no_done", 64'(saw_done), 64'(0));
      scan_and_check("empty", 1'b0, 1'b0, 1'b1, 0, 0, 32'h0);
      rf[3] = 32'h0000_0033;
      rf[7] = 32'h0000_0077;

      // x0 handling
      load(5'd0, 32'hFFFF_FFFF);
      scan_and_check("x0_zero", 1'b0, 1'b0, 1'b1, 0, 0, 32'h0);
      rf[0] = 32'h0000_0001;
`ifdef REGCHK_X0_EN
      scan_and_check("x0_one", 1'b0, 1'b0, 1'b0, 1, 0, 32'h0000_0001);
`else
      scan_and_check("x0_one", 1'b0, 1'b0, 1'b1, 0, 0, 32'h0);
`endif
      rf[0] = '0;

      // Inputs ignored while busy, start ignored in DONE
      load(5'd1, 32'h1234_5678);
      scan_and_check("poke", 1'b1, 1'b1, 1'b1, 0, 0, 32'h0);
      rf[1] = 32'h1234_5679;
      scan_and_check("poke_after", 1'b0, 1'b0, 1'b0, 1, 1, 32'h1234_5679);
      rf[1] = 32'h1234_5678;

      // Shadow clear, including clear+write in the same cycle
      for (int i = 10; i < 15; i++) load(5'(i), rf[i] + 32'd1);
      scan_and_check("five", 1'b0, 1'b0, 1'b0, 5, 10, rf[10]);
      exp_clr  = 1'b1;
      exp_wen  = 1'b1;
      exp_addr = 5'd5;
      exp_data = rf[5] + 32'd1;
      tick();
      exp_clr = 1'b0;
      exp_wen = 1'b0;
      scan_and_check("clr_wr", 1'b0, 1'b0, 1'b0, 1, 5, rf[5]);
      clear_shadow();
      scan_and_check("cleared", 1'b0, 1'b0, 1'b1, 0, 0, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
